// File: rtl/transfer_tx_pkg.sv
// Shared definitions for the transfer_tx serial command transmitter:
// command codes, frame geometry, filler byte, queue entry layout and FSM states.
package transfer_pkg;

    localparam logic [7:0] CMD_50     = 8'd1;
    localparam logic [7:0] CMD_80     = 8'd2;
    localparam logic [7:0] CMD_90     = 8'd3;
    localparam logic [7:0] CMD_100    = 8'd4;
    localparam logic [7:0] CMD_FLUSH  = 8'd5;
    localparam logic [7:0] CMD_READY  = 8'd6;
    localparam logic [7:0] CMD_BINARY = 8'd7;
    localparam logic [7:0] CMD_ASCII  = 8'd8;

    localparam int         FRAME_BITS = 8;
    localparam logic [7:0] FILLER     = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_CMD  = 2'd1,
        ST_SEND_DATA = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] data;
    } tx_entry_t;

    // A binary command is followed by its payload byte in the next frame.
    function automatic logic is_binary(input logic [7:0] cmd);
        return cmd == CMD_BINARY;
    endfunction

endpackage

// File: rtl/transfer_tx_if.sv
// Command-in / serial-out bundle of transfer_tx. The master side offers
// commands and observes the stream; the slave side is the transmitter.
interface transfer_tx_if;
    import transfer_pkg::*;

    logic [7:0]                      cmdIn;
    logic [7:0]                      dataByteIn;
    logic                            cmdValid;
    logic                            cmdReady;
    logic                            readyForTransferIn;
    logic                            dataOut;
    logic [$clog2(FRAME_BITS)-1:0]   slotCounter;
    logic                            busy;

    modport master (
        output cmdIn, dataByteIn, cmdValid, readyForTransferIn,
        input  cmdReady, dataOut, slotCounter, busy
    );

    modport slave (
        input  cmdIn, dataByteIn, cmdValid, readyForTransferIn,
        output cmdReady, dataOut, slotCounter, busy
    );

endinterface

// File: rtl/transfer_tx_fifo.sv
// Small circular queue of command entries with full/empty flags.
// A push is accepted while full when a pop happens on the same edge.
module transfer_tx_fifo #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_CNT);
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign rd_data_o = mem_q[rd_ptr_q];

    // Storage array; contents need no reset since count_q gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/transfer_tx.sv
// Continuous MSB-first serial transmitter of 8-bit command frames.
// Queue depth: 4 entries when TRANSFER_TX_FIFO_EN is defined, otherwise a
// single holding register. Idle frames carry the filler byte.
module transfer_tx
    import transfer_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    transfer_tx_if.slave bus
);
`ifdef TRANSFER_TX_FIFO_EN
    localparam int QUEUE_DEPTH = 4;
`else
    localparam int QUEUE_DEPTH = 1;
`endif
    localparam int SW = $clog2(FRAME_BITS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(FRAME_BITS - 1);

    logic [SW-1:0] slot_q;
    logic [SW-1:0] slot_d;
    logic [7:0]    shift_q;
    logic [7:0]    payload_q;
    logic          bin_q;
    tx_state_e     state_q;

    logic          boundary;
    logic          hold_pair;
    logic          pop;
    logic          push;
    logic          q_full;
    logic          q_empty;
    tx_entry_t     head;
    logic [15:0]   head_raw;

    assign slot_d    = slot_q + 1'b1;
    assign boundary  = (slot_q == LAST_SLOT);
    // A binary command's payload must follow immediately, whatever the queue
    // or downstream ready says.
    assign hold_pair = (state_q == ST_SEND_CMD) && bin_q;
    assign pop       = boundary && !hold_pair && !q_empty && bus.readyForTransferIn;
    assign push      = bus.cmdValid && !q_full;
    assign head      = tx_entry_t'(head_raw);

    transfer_tx_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i ({bus.cmdIn, bus.dataByteIn}),
        .rd_data_o (head_raw),
        .full_o    (q_full),
        .empty_o   (q_empty)
    );

    // Frame FSM: free-running slot counter, shift register and frame loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q    <= '0;
            shift_q   <= FILLER;
            payload_q <= 8'h00;
            bin_q     <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            slot_q <= slot_d;
            if (boundary) begin
                if (hold_pair) begin
                    shift_q <= payload_q;
                    bin_q   <= 1'b0;
                    state_q <= ST_SEND_DATA;
                end else if (pop) begin
                    shift_q   <= head.cmd;
                    payload_q <= head.data;
                    bin_q     <= is_binary(head.cmd);
                    state_q   <= ST_SEND_CMD;
                end else begin
                    shift_q <= FILLER;
                    bin_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            end else begin
                shift_q <= {shift_q[6:0], 1'b0};
            end
        end
    end

    assign bus.dataOut     = shift_q[7];
    assign bus.slotCounter = slot_q;
    assign bus.cmdReady    = !q_full;
    assign bus.busy        = !q_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_transfer_tx.sv
// Scoreboard bench for transfer_tx: stimulus pushes the expected frame byte
// and the cycle its frame starts; a monitor rebuilds every frame from dataOut
// and compares it against the queue head, or against filler when nothing is due.
module tb_transfer_tx;

    typedef struct {
        int         start;
        logic [7:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    transfer_tx_if bus ();

    transfer_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    // Frame monitor: assemble each full frame, then score it.
    logic [7:0] frame_bits = 8'h00;
    logic       collecting = 1'b0;
    int         frame_start = 0;
    always @(negedge clk) begin
        logic [7:0] expv;
        if (rst) begin
            collecting = 1'b0;
        end else begin
            if (bus.slotCounter == 3'd0) begin
                collecting  = 1'b1;
                frame_start = cyc;
                frame_bits  = 8'h00;
            end
            if (collecting) frame_bits = {frame_bits[6:0], bus.dataOut};
            if (collecting && bus.slotCounter == 3'd7) begin
                collecting = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].start < frame_start) begin
                    check("frame_missed_start", frame_start, exp_q[0].start);
                    void'(exp_q.pop_front());
                end
                expv = 8'h00;
                if (exp_q.size() > 0 && exp_q[0].start == frame_start) begin
                    expv = exp_q[0].val;
                    void'(exp_q.pop_front());
                end
                check("frame_byte", frame_bits, expv);
            end
        end
    end

    function automatic int exp_start(input int c, input int k);
        return c + 8 - k + ((k == 7) ? 8 : 0);
    endfunction

    task automatic expect_frame(input int start, input logic [7:0] val);
        exp_t e;
        e.start = start;
        e.val   = val;
        exp_q.push_back(e);
    endtask

    task automatic wait_slot(input int k);
        int n = 0;
        @(negedge clk);
        while (int'(bus.slotCounter) != k && n < 32) begin
            @(negedge clk);
            n++;
        end
        check("wait_slot_timeout", (n < 32), 1);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
        check("wait_cyc_overrun", cyc, t);
    endtask

    task automatic push(input logic [7:0] c, input logic [7:0] d, output int acc_c, output int acc_k);
        int n = 0;
        bus.cmdValid   = 1'b1;
        bus.cmdIn      = c;
        bus.dataByteIn = d;
        while (!bus.cmdReady && n < 64) begin
            @(negedge clk);
            n++;
        end
        acc_c = cyc;
        acc_k = int'(bus.slotCounter);
        check("push_accept_timeout", (n < 64), 1);
        @(posedge clk);
        #1;
        bus.cmdValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n < 300), 1);
        repeat (10) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_slot"},  bus.slotCounter, 0);
        check({tag, "_data"},  bus.dataOut, 0);
        check({tag, "_ready"}, bus.cmdReady, 1);
        check({tag, "_busy"},  bus.busy, 0);
    endtask

    initial begin
        int c1, k1, c2, k2, s;
        rst                    = 1'b1;
        bus.cmdIn              = 8'h00;
        bus.dataByteIn         = 8'h00;
        bus.cmdValid           = 1'b0;
        bus.readyForTransferIn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle: filler stream, slot counter free-running, not busy.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("idle_slot", bus.slotCounter, i % 8);
            check("idle_data", bus.dataOut, 0);
            check("idle_busy", bus.busy, 0);
        end

        // Single command accepted at slot 3.
        wait_slot(3);
        push(8'd1, 8'h00, c1, k1);
        s = exp_start(c1, k1);
        expect_frame(s, 8'h01);
        check("cmd1_busy_queued", bus.busy, 1);
        wait_cyc(s + 4);
        check("cmd1_busy_frame", bus.busy, 1);
        wait_cyc(s + 8);
        check("cmd1_busy_after", bus.busy, 0);
        drain();

        // Binary pair; downstream ready drops during the command frame.
        wait_slot(1);
        push(8'd7, 8'hA5, c1, k1);
        s = exp_start(c1, k1);
        expect_frame(s, 8'h07);
        expect_frame(s + 8, 8'hA5);
        wait_cyc(s + 2);
        bus.readyForTransferIn = 1'b0;
        check("bin_busy_cmd", bus.busy, 1);
        wait_cyc(s + 12);
        check("bin_busy_payload", bus.busy, 1);
        wait_cyc(s + 16);
        check("bin_busy_after", bus.busy, 0);
        check("bin_ready_after", bus.cmdReady, 1);
        bus.readyForTransferIn = 1'b1;
        drain();

        // Accept on the boundary edge is not popped until the next boundary.
        wait_slot(7);
        push(8'h02, 8'h00, c1, k1);
        check("edge_accept_slot", k1, 7);
        expect_frame(exp_start(c1, k1), 8'h02);
        drain();

`ifdef TRANSFER_TX_FIFO_EN
        // Four-deep queue held off by downstream, then released in order.
        bus.readyForTransferIn = 1'b0;
        wait_slot(0);
        push(8'h11, 8'h00, c1, k1);
        push(8'h22, 8'h00, c1, k1);
        push(8'h33, 8'h00, c1, k1);
        check("fifo_ready_3", bus.cmdReady, 1);
        push(8'h44, 8'h00, c1, k1);
        check("fifo_ready_full", bus.cmdReady, 0);
        check("fifo_busy_held", bus.busy, 1);
        fork
            push(8'h55, 8'h00, c2, k2);
            begin
                repeat (5) @(negedge clk);
                check("fifo_ready_still_full", bus.cmdReady, 0);
                bus.readyForTransferIn = 1'b1;
                s = cyc + 8 - int'(bus.slotCounter);
                expect_frame(s,      8'h11);
                expect_frame(s + 8,  8'h22);
                expect_frame(s + 16, 8'h33);
                expect_frame(s + 24, 8'h44);
            end
        join
        expect_frame(s + 32, 8'h55);
        drain();
`else
        // Holding register: second entry waits for the first one's pop.
        wait_slot(2);
        push(8'h04, 8'h00, c1, k1);
        s = exp_start(c1, k1);
        expect_frame(s, 8'h04);
        check("hold_ready_full", bus.cmdReady, 0);
        push(8'hC3, 8'h5A, c2, k2);
        check("hold_second_slot", k2, 0);
        check("hold_second_cyc", c2, s);
        expect_frame(exp_start(c2, k2), 8'hC3);
        drain();
`endif

        // Reset in the middle of a binary command frame.
        wait_slot(1);
        push(8'd7, 8'h3C, c1, k1);
        s = exp_start(c1, k1);
        wait_cyc(s + 4);
        check("rst_mid_slot", bus.slotCounter, 4);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("post_rst_data", bus.dataOut, 0);
            check("post_rst_busy", bus.busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
